// File: rtl/instr_fetch_decode.sv
// Instruction memory with fetch/decode stage: loads a program word-by-word in LOAD mode,
// then fetches mem[pc] in RUN mode, reports jump targets and registers the instruction.
`timescale 1ns/1ps
module instr_fetch_decode #(
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               state_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               load_valid_i,
  input  logic [INSTR_W-1:0] load_data_i,
  output logic               load_ready_o,
  output logic               load_o,
  output logic               load_full_o,
  input  logic               zero_flag_i,
  output logic [ADDR_W-1:0]  pc_count_o,
  output logic               instr_valid_o,
  output logic [3:0]         ir_opcode_o,
  output logic [3:0]         ir_operand_o,
  output logic               halted_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [3:0] OP_HALT = 4'hD;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [3:0]         ir_opcode_q, ir_opcode_d;
  logic [3:0]         ir_operand_q, ir_operand_d;
  logic               instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic [INSTR_W-1:0] word_s;
  logic [3:0]         opcode_s;
  logic [3:0]         operand_s;
  logic               load_ready_s;
  logic               load_s;
  logic [ADDR_W-1:0]  pc_count_s;

  assign word_s    = mem_q[pc_i];
  assign opcode_s  = word_s[INSTR_W-1 -: 4];
  assign operand_s = word_s[3:0];

  // Next-state, write handshake and fetch/decode; rst gates the handshake so it reads 0 in reset
  always_comb begin
    fsm_d         = fsm_q;
    wr_cnt_d      = wr_cnt_q;
    ir_opcode_d   = ir_opcode_q;
    ir_operand_d  = ir_operand_q;
    instr_valid_d = 1'b0;
    load_ready_s  = 1'b0;
    load_s        = 1'b0;
    pc_count_s    = {ADDR_W{1'b0}};
    case (fsm_q)
      ST_LOAD: begin
        load_ready_s = !rst && (wr_cnt_q < DEPTH_C);
        load_s       = load_valid_i && load_ready_s;
        if (load_s) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
        if (state_i) begin
          fsm_d = ST_RUN;
        end else begin
          fsm_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if ((opcode_s == OP_JMP) || ((opcode_s == OP_JZ) && zero_flag_i)) begin
          pc_count_s = ADDR_W'(operand_s);
        end else begin
          pc_count_s = {ADDR_W{1'b0}};
        end
        if (!state_i) begin
          fsm_d    = ST_LOAD;
          wr_cnt_d = {CNT_W{1'b0}};
        end else begin
          ir_opcode_d  = opcode_s;
          ir_operand_d = operand_s;
          // A captured HALT leaves instr_valid low so HALT state never reports a valid instruction
          if (opcode_s == OP_HALT) begin
            fsm_d = ST_HALT;
          end else begin
            instr_valid_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (!state_i) begin
          fsm_d    = ST_LOAD;
          wr_cnt_d = {CNT_W{1'b0}};
        end else begin
          fsm_d = ST_HALT;
        end
      end
      default: begin
        fsm_d    = ST_LOAD;
        wr_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control and instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= ST_LOAD;
      wr_cnt_q      <= {CNT_W{1'b0}};
      ir_opcode_q   <= 4'h0;
      ir_operand_q  <= 4'h0;
      instr_valid_q <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      wr_cnt_q      <= wr_cnt_d;
      ir_opcode_q   <= ir_opcode_d;
      ir_operand_q  <= ir_operand_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Program storage survives reset so a partially loaded program is kept
  always_ff @(posedge clk) begin
    if (load_s) begin
      mem_q[pc_i] <= load_data_i;
    end
  end

  assign load_ready_o  = load_ready_s;
  assign load_o        = load_s;
  assign load_full_o   = (fsm_q == ST_LOAD) && (wr_cnt_q == DEPTH_C);
  assign pc_count_o    = pc_count_s;
  assign instr_valid_o = instr_valid_q;
  assign ir_opcode_o   = ir_opcode_q;
  assign ir_operand_o  = ir_operand_q;
  assign halted_o      = (fsm_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed self-checking bench for instr_fetch_decode; the bench plays the role of the PC.
`timescale 1ns/1ps
module tb_instr_fetch_decode;

  logic       clk;
  logic       rst;
  logic       state;
  logic [3:0] pc;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load;
  logic       load_full;
  logic       zero_flag;
  logic [3:0] pc_count;
  logic       instr_valid;
  logic [3:0] ir_opcode;
  logic [3:0] ir_operand;
  logic       halted;

  int tests;
  int fails;

  instr_fetch_decode dut (
    .clk          (clk),
    .rst          (rst),
    .state_i      (state),
    .pc_i         (pc),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .load_o       (load),
    .load_full_o  (load_full),
    .zero_flag_i  (zero_flag),
    .pc_count_o   (pc_count),
    .instr_valid_o(instr_valid),
    .ir_opcode_o  (ir_opcode),
    .ir_operand_o (ir_operand),
    .halted_o     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 1'b0; pc = 4'h0; load_valid = 1'b0; load_data = 8'h00; zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({load_ready, load, load_full, pc_count, instr_valid, ir_opcode, ir_operand, halted} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {load_ready, load, load_full, pc_count, instr_valid, ir_opcode, ir_operand, halted});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (load_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b expected 1", load_ready);
    end
  endtask

  task automatic test_load_full();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pc = 4'(i); load_valid = 1'b1; load_data = 8'(8'h10 + i);
      #1;
      tests++;
      if (load !== 1'b1 || load_full !== 1'b0) begin
        fails++;
        $display("FAIL load_word%0d: got load=%b full=%b expected load=1 full=0", i, load, load_full);
      end
      tick();
    end
    @(negedge clk);
    pc = 4'h0; load_data = 8'hAA;
    #1;
    tests++;
    if (load_full !== 1'b1 || load_ready !== 1'b0 || load !== 1'b0) begin
      fails++;
      $display("FAIL load_full: got full=%b ready=%b load=%b expected 1 0 0", load_full, load_ready, load);
    end
    tick();
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_run_prog();
    logic [3:0] idx [3];
    logic [3:0] paddr [6];
    logic [7:0] pdata [6];
    idx[0] = 4'h0; idx[1] = 4'h3; idx[2] = 4'hF;
    paddr[0] = 4'h0; pdata[0] = 8'h00;
    paddr[1] = 4'h1; pdata[1] = 8'hF5;
    paddr[2] = 4'h2; pdata[2] = 8'hE7;
    paddr[3] = 4'h3; pdata[3] = 8'h01;
    paddr[4] = 4'h4; pdata[4] = 8'h02;
    paddr[5] = 4'h5; pdata[5] = 8'hD0;
    @(negedge clk);
    state = 1'b1; pc = 4'h0;
    tick();
    tests++;
    if (instr_valid !== 1'b0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL run_entry: got valid=%b halted=%b expected 0 0", instr_valid, halted);
    end
    // Full-load image, including a check that the rejected 17th word left mem[0] alone
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pc = idx[k];
      tick();
      tests++;
      if ({ir_opcode, ir_operand} !== {4'h1, idx[k]} || instr_valid !== 1'b1) begin
        fails++;
        $display("FAIL fetch_img%0d: got ir=%h valid=%b expected ir=%h valid=1",
                 k, {ir_opcode, ir_operand}, instr_valid, {4'h1, idx[k]});
      end
    end
    @(negedge clk);
    state = 1'b0;
    tick();
    tests++;
    if (instr_valid !== 1'b0 || load_ready !== 1'b1) begin
      fails++;
      $display("FAIL back_to_load: got valid=%b ready=%b expected 0 1", instr_valid, load_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pc = paddr[k]; load_data = pdata[k]; load_valid = 1'b1;
      tick();
    end
    @(negedge clk);
    load_valid = 1'b0; state = 1'b1; pc = 4'h0;
    tick();
    @(negedge clk);
    pc = 4'h0;
    #1;
    tests++;
    if (pc_count !== 4'h0) begin
      fails++;
      $display("FAIL nop_pc_count: got %h expected 0", pc_count);
    end
    tick();
    tests++;
    if ({ir_opcode, ir_operand} !== 8'h00 || instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL ir_nop: got ir=%h valid=%b expected 00 1", {ir_opcode, ir_operand}, instr_valid);
    end
    @(negedge clk);
    pc = 4'h1;
    #1;
    tests++;
    if (pc_count !== 4'h5) begin
      fails++;
      $display("FAIL jmp_pc_count: got %h expected 5", pc_count);
    end
    tick();
    tests++;
    if ({ir_opcode, ir_operand} !== 8'hF5) begin
      fails++;
      $display("FAIL ir_jmp: got %h expected F5", {ir_opcode, ir_operand});
    end
    @(negedge clk);
    pc = 4'h5;
    tick();
    tests++;
    if ({ir_opcode, ir_operand} !== 8'hD0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL ir_halt: got ir=%h halted=%b valid=%b expected D0 1 0",
               {ir_opcode, ir_operand}, halted, instr_valid);
    end
    @(negedge clk);
    pc = 4'h1;
    #1;
    tests++;
    if (pc_count !== 4'h0) begin
      fails++;
      $display("FAIL halt_no_jump: got %h expected 0", pc_count);
    end
    tick();
    tests++;
    if ({ir_opcode, ir_operand} !== 8'hD0 || halted !== 1'b1) begin
      fails++;
      $display("FAIL halt_hold: got ir=%h halted=%b expected D0 1", {ir_opcode, ir_operand}, halted);
    end
  endtask

  task automatic test_halt_exit();
    @(negedge clk);
    state = 1'b0; load_valid = 1'b1; load_data = 8'h77; pc = 4'h6;
    #1;
    tests++;
    if (load !== 1'b0) begin
      fails++;
      $display("FAIL drop_and_valid: got load=%b expected 0", load);
    end
    tick();
    tests++;
    if (halted !== 1'b0 || load_ready !== 1'b1 || load_full !== 1'b0) begin
      fails++;
      $display("FAIL halt_exit: got halted=%b ready=%b full=%b expected 0 1 0", halted, load_ready, load_full);
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_jz();
    @(negedge clk);
    state = 1'b1;
    tick();
    @(negedge clk);
    pc = 4'h2; zero_flag = 1'b0;
    #1;
    tests++;
    if (pc_count !== 4'h0) begin
      fails++;
      $display("FAIL jz_not_taken: got %h expected 0", pc_count);
    end
    zero_flag = 1'b1;
    #1;
    tests++;
    if (pc_count !== 4'h7) begin
      fails++;
      $display("FAIL jz_taken: got %h expected 7", pc_count);
    end
    tick();
    tests++;
    if ({ir_opcode, ir_operand} !== 8'hE7 || instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL ir_jz: got ir=%h valid=%b expected E7 1", {ir_opcode, ir_operand}, instr_valid);
    end
    @(negedge clk);
    pc = 4'h6; zero_flag = 1'b0;
    tick();
    tests++;
    if ({ir_opcode, ir_operand} !== 8'h16) begin
      fails++;
      $display("FAIL no_write_on_drop: got %h expected 16", {ir_opcode, ir_operand});
    end
  endtask

  task automatic test_rst_mid_run();
    @(negedge clk);
    pc = 4'h3;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({load_ready, load, load_full, pc_count, instr_valid, ir_opcode, ir_operand, halted} !== 16'h0000) begin
      fails++;
      $display("FAIL rst_async: got %h expected 0000",
               {load_ready, load, load_full, pc_count, instr_valid, ir_opcode, ir_operand, halted});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (load_ready !== 1'b1 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_to_load: got ready=%b valid=%b expected 1 0", load_ready, instr_valid);
    end
    tick();
    @(negedge clk);
    pc = 4'h1;
    tick();
    tests++;
    if ({ir_opcode, ir_operand} !== 8'hF5) begin
      fails++;
      $display("FAIL mem_kept: got %h expected F5", {ir_opcode, ir_operand});
    end
    @(negedge clk);
    pc = 4'h5;
    tick();
    tests++;
    if (halted !== 1'b1) begin
      fails++;
      $display("FAIL rerun_halt: got %b expected 1", halted);
    end
  endtask

  task automatic test_toggle();
    int accepted;
    logic want;
    accepted = 0;
    @(negedge clk);
    state = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      want = (k % 2 == 0);
      pc = 4'(k); load_valid = want; load_data = 8'(8'hA0 + k);
      #1;
      tests++;
      if (load !== want) begin
        fails++;
        $display("FAIL toggle%0d: got load=%b expected %b", k, load, want);
      end
      if (load === 1'b1) accepted++;
      tick();
    end
    tests++;
    if (accepted != 4) begin
      fails++;
      $display("FAIL toggle_count: got %0d expected 4", accepted);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      pc = 4'(8 + k); load_valid = 1'b1; load_data = 8'h55;
      #1;
      tests++;
      if (load_full !== 1'b0 || load !== 1'b1) begin
        fails++;
        $display("FAIL fill%0d: got full=%b load=%b expected 0 1", k, load_full, load);
      end
      tick();
    end
    tests++;
    if (load_full !== 1'b1 || load_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: got full=%b ready=%b expected 1 0", load_full, load_ready);
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load_full();
    test_run_prog();
    test_halt_exit();
    test_jz();
    test_rst_mid_run();
    test_toggle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
